// File: rtl/mem_noc_arb_nto1_pkg.sv
// Request and response payload types shared by the memory NoC arbiter and its masters and slave.
package mem_noc_arb_nto1_pkg;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        resp_last;
    } mem_resp_t;

endpackage

// File: rtl/mem_noc_arb_nto1.sv
// N-master to 1-slave round-robin arbiter: zero-cycle request path, responses routed in order via a grant-ID FIFO.
// Backpressure: requests stall while the slave is not ready or MAX_OUTST are in flight; responses stall on the owner's ready.
module mem_noc_arb_nto1
    import mem_noc_arb_nto1_pkg::*;
#(
    parameter int N_MST     = 2,
    parameter int MAX_OUTST = 4,
    parameter int TID_W     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic      [N_MST-1:0]                 m_req_valid,
    output logic      [N_MST-1:0]                 m_req_ready,
    input  mem_req_t  [N_MST-1:0]                 m_req,
    input  logic      [N_MST-1:0][TID_W-1:0]      m_tid,
    output logic      [N_MST-1:0]                 m_resp_valid,
    input  logic      [N_MST-1:0]                 m_resp_ready,
    output mem_resp_t [N_MST-1:0]                 m_resp,
    output logic                                  sn_req_valid,
    input  logic                                  sn_req_ready,
    output mem_req_t                              sn_req,
    input  logic      [TID_W-1:0]                 sn_tid,
    input  logic                                  sn_resp_valid,
    output logic                                  sn_resp_ready,
    input  mem_resp_t                             sn_resp,
    output logic      [$clog2(MAX_OUTST+1)-1:0]   outst_cnt,
    output logic                                  err_unexp_resp
);

    localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic          lock_q, lock_d;
    logic [GW-1:0] lock_idx_q, lock_idx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [GW-1:0] fifo_q [MAX_OUTST];
    logic [GW-1:0] fifo_d [MAX_OUTST];

    logic [N_MST-1:0] elig;
    logic             any_elig;
    logic [GW:0]      rr_sum;
    logic [GW-1:0]    rr_idx;
    logic [GW-1:0]    rr_grant;
    logic             rr_hit;
    logic [GW-1:0]    grant;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [GW-1:0]    owner;

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            elig[i] = m_req_valid[i] && (m_tid[i] == sn_tid);
        end
    end

    assign any_elig = |elig;

    // First eligible master at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        rr_grant = rr_ptr_q;
        rr_hit   = 1'b0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int k = 0; k < N_MST; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (rr_sum >= (GW+1)'(N_MST)) begin
                rr_sum = rr_sum - (GW+1)'(N_MST);
            end
            rr_idx = rr_sum[GW-1:0];
            if (!rr_hit && elig[rr_idx]) begin
                rr_grant = rr_idx;
                rr_hit   = 1'b1;
            end
        end
    end

    assign grant = lock_q ? lock_idx_q : rr_grant;
    assign full  = (cnt_q == CW'(MAX_OUTST));
    assign empty = (cnt_q == '0);
    assign owner = fifo_q[rd_ptr_q];

    assign sn_req_valid = !rst && any_elig && !full;
    assign sn_req       = m_req[grant];
    assign push         = sn_req_valid && sn_req_ready;

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            m_req_ready[i] = sn_req_valid && sn_req_ready && (grant == GW'(i));
        end
    end

    assign sn_resp_ready = !rst && !empty && m_resp_ready[owner];
    assign pop           = sn_resp_valid && sn_resp_ready && sn_resp.resp_last;

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            m_resp_valid[i] = 1'b0;
            m_resp[i]       = '0;
            if (!rst && !empty && (owner == GW'(i))) begin
                m_resp_valid[i] = sn_resp_valid;
                m_resp[i]       = sn_resp;
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (push) begin
            rr_ptr_d = (grant == GW'(N_MST - 1)) ? '0 : grant + GW'(1);
            lock_d   = 1'b0;
        end else if (sn_req_valid) begin
            // Slave stalled: pin the grant so the presented request cannot change under it.
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign err_d = err_q || (sn_resp_valid && empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign outst_cnt      = cnt_q;
    assign err_unexp_resp = err_q;

endmodule

// File: tb/tb_mem_noc_arb_nto1.sv
// Directed bench for mem_noc_arb_nto1 with three masters and four outstanding requests.
module tb_mem_noc_arb_nto1;
    import mem_noc_arb_nto1_pkg::*;

    localparam int N_MST     = 3;
    localparam int MAX_OUTST = 4;
    localparam int TID_W     = 1;

    logic                              clk = 1'b0;
    logic                              rst;
    logic      [N_MST-1:0]             m_req_valid;
    logic      [N_MST-1:0]             m_req_ready;
    mem_req_t  [N_MST-1:0]             m_req;
    logic      [N_MST-1:0][TID_W-1:0]  m_tid;
    logic      [N_MST-1:0]             m_resp_valid;
    logic      [N_MST-1:0]             m_resp_ready;
    mem_resp_t [N_MST-1:0]             m_resp;
    logic                              sn_req_valid;
    logic                              sn_req_ready;
    mem_req_t                          sn_req;
    logic      [TID_W-1:0]             sn_tid;
    logic                              sn_resp_valid;
    logic                              sn_resp_ready;
    mem_resp_t                         sn_resp;
    logic      [2:0]                   outst_cnt;
    logic                              err_unexp_resp;

    int checks   = 0;
    int failures = 0;

    mem_noc_arb_nto1 #(.N_MST(N_MST), .MAX_OUTST(MAX_OUTST), .TID_W(TID_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .m_req_valid    (m_req_valid),
        .m_req_ready    (m_req_ready),
        .m_req          (m_req),
        .m_tid          (m_tid),
        .m_resp_valid   (m_resp_valid),
        .m_resp_ready   (m_resp_ready),
        .m_resp         (m_resp),
        .sn_req_valid   (sn_req_valid),
        .sn_req_ready   (sn_req_ready),
        .sn_req         (sn_req),
        .sn_tid         (sn_tid),
        .sn_resp_valid  (sn_resp_valid),
        .sn_resp_ready  (sn_resp_ready),
        .sn_resp        (sn_resp),
        .outst_cnt      (outst_cnt),
        .err_unexp_resp (err_unexp_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_req_valid = 3'b111;
        sn_req_ready = 1'b1;
        sn_resp_valid = 1'b1;
        sn_resp = '{rdata: 32'h0, resp_last: 1'b1};
        m_resp_ready = 3'b111;
        tick();
        tick();
        checks++; if (sn_req_valid !== 1'b0) begin failures++; $display("FAIL rst_sn_req_valid got=%0b exp=0", sn_req_valid); end
        checks++; if (m_req_ready !== 3'b000) begin failures++; $display("FAIL rst_m_req_ready got=%b exp=000", m_req_ready); end
        checks++; if (m_resp_valid !== 3'b000) begin failures++; $display("FAIL rst_m_resp_valid got=%b exp=000", m_resp_valid); end
        checks++; if (sn_resp_ready !== 1'b0) begin failures++; $display("FAIL rst_sn_resp_ready got=%0b exp=0", sn_resp_ready); end
        checks++; if (outst_cnt !== 3'd0) begin failures++; $display("FAIL rst_outst_cnt got=%0d exp=0", outst_cnt); end
        checks++; if (err_unexp_resp !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_unexp_resp); end
        m_req_valid = '0;
        sn_req_ready = 1'b0;
        sn_resp_valid = 1'b0;
        m_resp_ready = '0;
        rst = 1'b0;
        tick();
        checks++; if (outst_cnt !== 3'd0 || err_unexp_resp !== 1'b0) begin failures++; $display("FAIL post_rst cnt=%0d err=%0b exp cnt=0 err=0", outst_cnt, err_unexp_resp); end
    endtask

    task automatic test_rr_fill();
        logic [2:0] e;
        m_req_valid = 3'b111;
        sn_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = 3'b001 << (k % 3);
            #1;
            checks++; if (m_req_ready !== e) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, m_req_ready, e); end
            checks++; if (sn_req.addr !== 16'h100 + 16'(k % 3)) begin failures++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, sn_req.addr, 16'h100 + 16'(k % 3)); end
            checks++; if (outst_cnt !== 3'(k)) begin failures++; $display("FAIL rr_cnt k=%0d got=%0d exp=%0d", k, outst_cnt, k); end
            tick();
        end
        checks++; if (sn_req_valid !== 1'b0 || m_req_ready !== 3'b000) begin failures++; $display("FAIL rr_full vld=%0b rdy=%b exp 0/000", sn_req_valid, m_req_ready); end
        checks++; if (outst_cnt !== 3'd4) begin failures++; $display("FAIL rr_full_cnt got=%0d exp=4", outst_cnt); end
        tick();
        checks++; if (outst_cnt !== 3'd4) begin failures++; $display("FAIL rr_hold_cnt got=%0d exp=4", outst_cnt); end
        m_req_valid = '0;
        sn_resp_valid = 1'b1;
        m_resp_ready = 3'b111;
        for (int k = 0; k < 4; k++) begin
            e = 3'b001 << (k % 3);
            sn_resp = '{rdata: 32'hD0 + 32'(k), resp_last: 1'b1};
            #1;
            checks++; if (m_resp_valid !== e) begin failures++; $display("FAIL drain_owner k=%0d got=%b exp=%b", k, m_resp_valid, e); end
            checks++; if (m_resp[k % 3].rdata !== 32'hD0 + 32'(k)) begin failures++; $display("FAIL drain_data k=%0d got=%h exp=%h", k, m_resp[k % 3].rdata, 32'hD0 + 32'(k)); end
            if (k == 0) begin
                checks++; if (m_resp[1] !== '0) begin failures++; $display("FAIL drain_nonowner_zero got=%h exp=0", m_resp[1]); end
            end
            checks++; if (outst_cnt !== 3'(4 - k)) begin failures++; $display("FAIL drain_cnt k=%0d got=%0d exp=%0d", k, outst_cnt, 4 - k); end
            tick();
        end
        sn_resp_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 3'd0) begin failures++; $display("FAIL drain_end_cnt got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_lock();
        logic [2:0] e;
        m_req_valid = 3'b100;
        sn_req_ready = 1'b1;
        #1;
        checks++; if (m_req_ready !== 3'b100) begin failures++; $display("FAIL lock_prime got=%b exp=100", m_req_ready); end
        tick();
        m_req_valid = 3'b010;
        sn_req_ready = 1'b0;
        #1;
        checks++; if (sn_req_valid !== 1'b1 || sn_req.addr !== 16'h101) begin failures++; $display("FAIL lock_present vld=%0b addr=%h exp 1/0101", sn_req_valid, sn_req.addr); end
        checks++; if (m_req_ready !== 3'b000) begin failures++; $display("FAIL lock_stall_rdy got=%b exp=000", m_req_ready); end
        tick();
        m_req_valid = 3'b011;
        for (int s = 0; s < 2; s++) begin
            #1;
            checks++; if (sn_req.addr !== 16'h101 || m_req_ready !== 3'b000) begin failures++; $display("FAIL lock_hold s=%0d addr=%h rdy=%b exp 0101/000", s, sn_req.addr, m_req_ready); end
            tick();
        end
        sn_req_ready = 1'b1;
        #1;
        checks++; if (m_req_ready !== 3'b010 || sn_req.addr !== 16'h101) begin failures++; $display("FAIL lock_release rdy=%b addr=%h exp 010/0101", m_req_ready, sn_req.addr); end
        tick();
        m_req_valid = 3'b001;
        #1;
        checks++; if (m_req_ready !== 3'b001) begin failures++; $display("FAIL lock_next got=%b exp=001", m_req_ready); end
        tick();
        m_req_valid = '0;
        checks++; if (outst_cnt !== 3'd3) begin failures++; $display("FAIL lock_cnt got=%0d exp=3", outst_cnt); end
        sn_resp_valid = 1'b1;
        sn_resp = '{rdata: 32'h55, resp_last: 1'b1};
        m_resp_ready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            e = 3'b100 >> k;
            #1;
            checks++; if (m_resp_valid !== e) begin failures++; $display("FAIL lock_drain k=%0d got=%b exp=%b", k, m_resp_valid, e); end
            tick();
        end
        sn_resp_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 3'd0) begin failures++; $display("FAIL lock_drain_cnt got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_multibeat();
        m_req_valid = 3'b001;
        sn_req_ready = 1'b1;
        #1;
        checks++; if (m_req_ready !== 3'b001) begin failures++; $display("FAIL mb_acc0 got=%b exp=001", m_req_ready); end
        tick();
        m_req_valid = 3'b100;
        #1;
        checks++; if (m_req_ready !== 3'b100) begin failures++; $display("FAIL mb_acc2 got=%b exp=100", m_req_ready); end
        tick();
        m_req_valid = '0;
        checks++; if (outst_cnt !== 3'd2) begin failures++; $display("FAIL mb_cnt2 got=%0d exp=2", outst_cnt); end
        sn_resp_valid = 1'b1;
        sn_resp = '{rdata: 32'hA0, resp_last: 1'b0};
        m_resp_ready = 3'b110;
        #1;
        checks++; if (m_resp_valid !== 3'b001 || sn_resp_ready !== 1'b0) begin failures++; $display("FAIL mb_bp vld=%b rdy=%0b exp 001/0", m_resp_valid, sn_resp_ready); end
        tick();
        m_resp_ready = 3'b111;
        #1;
        checks++; if (sn_resp_ready !== 1'b1 || m_resp[0].rdata !== 32'hA0) begin failures++; $display("FAIL mb_beat1 rdy=%0b data=%h exp 1/a0", sn_resp_ready, m_resp[0].rdata); end
        tick();
        checks++; if (outst_cnt !== 3'd2) begin failures++; $display("FAIL mb_nonlast_cnt got=%0d exp=2", outst_cnt); end
        sn_resp = '{rdata: 32'hA1, resp_last: 1'b1};
        #1;
        checks++; if (m_resp_valid !== 3'b001 || m_resp[0].rdata !== 32'hA1) begin failures++; $display("FAIL mb_beat2 vld=%b data=%h exp 001/a1", m_resp_valid, m_resp[0].rdata); end
        tick();
        checks++; if (outst_cnt !== 3'd1) begin failures++; $display("FAIL mb_cnt1 got=%0d exp=1", outst_cnt); end
        sn_resp = '{rdata: 32'hB0, resp_last: 1'b1};
        #1;
        checks++; if (m_resp_valid !== 3'b100 || m_resp[2].rdata !== 32'hB0) begin failures++; $display("FAIL mb_m2 vld=%b data=%h exp 100/b0", m_resp_valid, m_resp[2].rdata); end
        checks++; if (m_resp[0] !== '0) begin failures++; $display("FAIL mb_m0_zero got=%h exp=0", m_resp[0]); end
        tick();
        sn_resp_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 3'd0) begin failures++; $display("FAIL mb_cnt0 got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_full_pop();
        m_req_valid = 3'b001;
        sn_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (outst_cnt !== 3'd4 || sn_req_valid !== 1'b0) begin failures++; $display("FAIL fp_full cnt=%0d vld=%0b exp 4/0", outst_cnt, sn_req_valid); end
        m_req_valid = 3'b010;
        sn_resp_valid = 1'b1;
        sn_resp = '{rdata: 32'h77, resp_last: 1'b1};
        m_resp_ready = 3'b111;
        #1;
        checks++; if (sn_req_valid !== 1'b0 || m_req_ready !== 3'b000 || sn_resp_ready !== 1'b1) begin failures++; $display("FAIL fp_same_cycle vld=%0b rdy=%b srdy=%0b exp 0/000/1", sn_req_valid, m_req_ready, sn_resp_ready); end
        tick();
        sn_resp_valid = 1'b0;
        checks++; if (outst_cnt !== 3'd3) begin failures++; $display("FAIL fp_cnt3 got=%0d exp=3", outst_cnt); end
        #1;
        checks++; if (m_req_ready !== 3'b010) begin failures++; $display("FAIL fp_accept_next got=%b exp=010", m_req_ready); end
        tick();
        m_req_valid = '0;
        checks++; if (outst_cnt !== 3'd4) begin failures++; $display("FAIL fp_cnt4 got=%0d exp=4", outst_cnt); end
        sn_resp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k == 3) begin
                checks++; if (m_resp_valid !== 3'b010) begin failures++; $display("FAIL fp_wrap_owner got=%b exp=010", m_resp_valid); end
            end
            tick();
        end
        sn_resp_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 3'd0) begin failures++; $display("FAIL fp_drain_cnt got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_tid();
        m_tid[1] = 1'b1;
        m_req_valid = 3'b010;
        sn_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (sn_req_valid !== 1'b0 || m_req_ready !== 3'b000) begin failures++; $display("FAIL tid_block k=%0d vld=%0b rdy=%b exp 0/000", k, sn_req_valid, m_req_ready); end
            tick();
        end
        checks++; if (outst_cnt !== 3'd0) begin failures++; $display("FAIL tid_cnt got=%0d exp=0", outst_cnt); end
        sn_tid = 1'b1;
        #1;
        checks++; if (sn_req_valid !== 1'b1 || m_req_ready !== 3'b010) begin failures++; $display("FAIL tid_match vld=%0b rdy=%b exp 1/010", sn_req_valid, m_req_ready); end
        m_req_valid = '0;
        sn_tid = 1'b0;
        m_tid[1] = 1'b0;
        #1;
    endtask

    task automatic test_unexp_reset();
        sn_resp_valid = 1'b1;
        sn_resp = '{rdata: 32'h99, resp_last: 1'b1};
        m_resp_ready = 3'b111;
        #1;
        checks++; if (sn_resp_ready !== 1'b0 || m_resp_valid !== 3'b000 || err_unexp_resp !== 1'b0) begin failures++; $display("FAIL unexp_comb srdy=%0b vld=%b err=%0b exp 0/000/0", sn_resp_ready, m_resp_valid, err_unexp_resp); end
        tick();
        checks++; if (err_unexp_resp !== 1'b1) begin failures++; $display("FAIL unexp_set got=%0b exp=1", err_unexp_resp); end
        sn_resp_valid = 1'b0;
        tick();
        checks++; if (err_unexp_resp !== 1'b1) begin failures++; $display("FAIL unexp_sticky got=%0b exp=1", err_unexp_resp); end
        m_req_valid = 3'b001;
        sn_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        m_req_valid = '0;
        checks++; if (outst_cnt !== 3'd3) begin failures++; $display("FAIL burst_cnt got=%0d exp=3", outst_cnt); end
        sn_resp_valid = 1'b1;
        sn_resp = '{rdata: 32'h11, resp_last: 1'b0};
        tick();
        rst = 1'b1;
        m_req_valid = 3'b111;
        #1;
        checks++; if (sn_req_valid !== 1'b0 || m_req_ready !== 3'b000 || m_resp_valid !== 3'b000 || sn_resp_ready !== 1'b0) begin failures++; $display("FAIL midrst_outs vld=%0b rdy=%b rvld=%b srdy=%0b exp all 0", sn_req_valid, m_req_ready, m_resp_valid, sn_resp_ready); end
        tick();
        checks++; if (outst_cnt !== 3'd0 || err_unexp_resp !== 1'b0) begin failures++; $display("FAIL midrst_state cnt=%0d err=%0b exp 0/0", outst_cnt, err_unexp_resp); end
        rst = 1'b0;
        m_req_valid = '0;
        sn_req_ready = 1'b0;
        sn_resp_valid = 1'b0;
        m_resp_ready = '0;
        tick();
        checks++; if (outst_cnt !== 3'd0 || sn_resp_ready !== 1'b0 || sn_req_valid !== 1'b0 || err_unexp_resp !== 1'b0) begin failures++; $display("FAIL post_midrst cnt=%0d srdy=%0b vld=%0b err=%0b exp all 0", outst_cnt, sn_resp_ready, sn_req_valid, err_unexp_resp); end
    endtask

    initial begin
        rst = 1'b1;
        m_req_valid = '0;
        m_resp_ready = '0;
        m_tid = '0;
        sn_tid = '0;
        sn_req_ready = 1'b0;
        sn_resp_valid = 1'b0;
        sn_resp = '0;
        for (int i = 0; i < N_MST; i++) begin
            m_req[i] = '{we: 1'b0, addr: 16'h100 + 16'(i), wdata: 32'hC0DE0000 + 32'(i)};
        end
        test_reset();
        test_rr_fill();
        test_lock();
        test_multibeat();
        test_full_pop();
        test_tid();
        test_unexp_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
